// File: rtl/word_to_byte_serializer_pkg.sv
// Shared constants for the 16-to-8 narrowing path: state encoding, mode codes
// and a byte-select helper.
package word_to_byte_serializer_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 2 * BYTE_W;

  localparam logic MODE_BYTE = 1'b0;
  localparam logic MODE_WORD = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2
  } state_e;

  function automatic logic [BYTE_W-1:0] pick_byte(input logic [WORD_W-1:0] word,
                                                  input logic             high);
    return high ? word[WORD_W-1:BYTE_W] : word[BYTE_W-1:0];
  endfunction

endpackage

// File: rtl/word_to_byte_serializer_sat_counter.sv
// Saturating event counter with a synchronous clear that wins over increment.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && !(&cnt_q))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/word_to_byte_serializer.sv
// Narrows 16-bit words to 8-bit valid/ready beats: one truncated beat in byte
// mode, two beats in word mode, with back-to-back acceptance on the last beat.
module word_to_byte_serializer
  import word_to_byte_serializer_pkg::*;
#(
  parameter int HIGH_FIRST = 0,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_last,
  output logic              trunc,
  output logic [CNT_W-1:0]  trunc_cnt,
  input  logic              clr_cnt,
  output logic              busy
);

  localparam logic HI_FIRST = (HIGH_FIRST != 0);

  state_e            state_q;
  logic [WORD_W-1:0] word_q;
  logic              mode_q;
  logic              out_valid_q;
  logic [BYTE_W-1:0] out_data_q;
  logic              out_last_q;
  logic              trunc_q;

  logic in_xfer, beat_xfer, first_high_d;

  // A new word may enter while the final beat of the current one leaves.
  assign in_ready     = (state_q == ST_IDLE) || (out_valid_q && out_ready && out_last_q);
  assign in_xfer      = in_valid && in_ready;
  assign beat_xfer    = out_valid_q && out_ready;
  assign first_high_d = (in_mode == MODE_WORD) && HI_FIRST;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      word_q      <= '0;
      mode_q      <= MODE_BYTE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      trunc_q     <= 1'b0;
    end else if (in_xfer) begin
      state_q     <= ST_BEAT0;
      word_q      <= in_data;
      mode_q      <= in_mode;
      out_valid_q <= 1'b1;
      out_data_q  <= pick_byte(in_data, first_high_d);
      out_last_q  <= (in_mode == MODE_BYTE);
      trunc_q     <= (in_mode == MODE_BYTE) && (in_data[WORD_W-1:BYTE_W] != '0);
    end else begin
      case (state_q)
        ST_BEAT0: begin
          if (out_ready) begin
            if (mode_q == MODE_WORD) begin
              state_q    <= ST_BEAT1;
              out_data_q <= pick_byte(word_q, !HI_FIRST);
              out_last_q <= 1'b1;
              trunc_q    <= 1'b0;
            end else begin
              state_q     <= ST_IDLE;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              trunc_q     <= 1'b0;
            end
          end
        end
        ST_BEAT1: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            trunc_q     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_trunc_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (clr_cnt),
    .inc_i (beat_xfer && trunc_q),
    .cnt_o (trunc_cnt)
  );

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign trunc     = trunc_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_word_to_byte_serializer.sv
// Two serializers share one stimulus stream: low-first with an 8-bit counter and
// high-first with a 2-bit counter; each is compared against a queue-based model.
module tb_word_to_byte_serializer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_mode = 1'b0;
  logic        out_ready = 1'b0;
  logic        clr_cnt = 1'b0;

  logic       a_in_ready, a_out_valid, a_out_last, a_trunc, a_busy;
  logic [7:0] a_out_data, a_trunc_cnt;
  logic       b_in_ready, b_out_valid, b_out_last, b_trunc, b_busy;
  logic [7:0] b_out_data;
  logic [1:0] b_trunc_cnt;

  int errors = 0;
  int checks = 0;

  // beat entries: {trunc, last, data}
  logic [9:0] qa[$];
  logic [9:0] qb[$];
  int cnt_a = 0;
  int cnt_b = 0;

  always #5 clk = ~clk;

  word_to_byte_serializer #(.HIGH_FIRST(0), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_mode(in_mode), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_data(a_out_data), .out_last(a_out_last),
    .trunc(a_trunc), .trunc_cnt(a_trunc_cnt), .clr_cnt(clr_cnt), .busy(a_busy)
  );

  word_to_byte_serializer #(.HIGH_FIRST(1), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_mode(in_mode), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_data(b_out_data), .out_last(b_out_last),
    .trunc(b_trunc), .trunc_cnt(b_trunc_cnt), .clr_cnt(clr_cnt), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit exp_rdy;
    exp_rdy = (qa.size() == 0) || (out_ready && qa[0][8]);
    chk("a_out_valid", {31'd0, a_out_valid}, {31'd0, qa.size() != 0});
    chk("b_out_valid", {31'd0, b_out_valid}, {31'd0, qb.size() != 0});
    chk("a_busy", {31'd0, a_busy}, {31'd0, qa.size() != 0});
    chk("b_busy", {31'd0, b_busy}, {31'd0, qb.size() != 0});
    chk("a_in_ready", {31'd0, a_in_ready}, {31'd0, exp_rdy});
    chk("b_in_ready", {31'd0, b_in_ready}, {31'd0, exp_rdy});
    if (qa.size() != 0)
      chk("a_beat", {22'd0, a_trunc, a_out_last, a_out_data}, {22'd0, qa[0]});
    if (qb.size() != 0)
      chk("b_beat", {22'd0, b_trunc, b_out_last, b_out_data}, {22'd0, qb[0]});
    chk("a_trunc_cnt", {24'd0, a_trunc_cnt}, cnt_a);
    chk("b_trunc_cnt", {30'd0, b_trunc_cnt}, cnt_b);
  endtask

  // One clock: drive inputs, check, advance model to the coming edge, clock.
  task automatic cycle(input logic iv, input logic [15:0] d, input logic m,
                       input logic ordy, input logic clr);
    bit acc, tr;
    in_valid  = iv;
    in_data   = d;
    in_mode   = m;
    out_ready = ordy;
    clr_cnt   = clr;
    #1;
    check_outputs();
    acc = iv && ((qa.size() == 0) || (ordy && qa[0][8]));
    if (qa.size() != 0 && ordy) begin
      tr = qa[0][9];
      void'(qa.pop_front());
      void'(qb.pop_front());
      if (tr) begin
        if (cnt_a < 255) cnt_a++;
        if (cnt_b < 3) cnt_b++;
      end
    end
    if (clr) begin
      cnt_a = 0;
      cnt_b = 0;
    end
    if (acc) begin
      if (m == 1'b0) begin
        qa.push_back({d[15:8] != 8'h00, 1'b1, d[7:0]});
        qb.push_back({d[15:8] != 8'h00, 1'b1, d[7:0]});
      end else begin
        qa.push_back({2'b00, d[7:0]});
        qa.push_back({2'b01, d[15:8]});
        qb.push_back({2'b00, d[15:8]});
        qb.push_back({2'b01, d[7:0]});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    #1;
    qa.delete();
    qb.delete();
    cnt_a = 0;
    cnt_b = 0;
    chk("rst_a_out_valid", {31'd0, a_out_valid}, 32'd0);
    chk("rst_b_out_valid", {31'd0, b_out_valid}, 32'd0);
    chk("rst_a_busy", {31'd0, a_busy}, 32'd0);
    chk("rst_a_outs", {22'd0, a_trunc, a_out_last, a_out_data}, 32'd0);
    chk("rst_b_outs", {22'd0, b_trunc, b_out_last, b_out_data}, 32'd0);
    chk("rst_a_cnt", {24'd0, a_trunc_cnt}, 32'd0);
    chk("rst_b_cnt", {30'd0, b_trunc_cnt}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    do_reset();
    idle(1);

    // byte mode, no truncation
    cycle(1'b1, 16'h00A5, 1'b0, 1'b1, 1'b0);
    idle(2);

    // byte mode with truncation, then clear
    cycle(1'b1, 16'h12A5, 1'b0, 1'b1, 1'b0);
    idle(2);
    cycle(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
    idle(1);

    // word mode: both beat orders at once
    cycle(1'b1, 16'hBEEF, 1'b1, 1'b1, 1'b0);
    idle(3);

    // back-to-back byte words
    cycle(1'b1, 16'h0001, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 16'h0002, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 16'h0003, 1'b0, 1'b1, 1'b0);
    idle(2);

    // back-to-back word-mode words
    cycle(1'b1, 16'hA1B2, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 16'hC3D4, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 16'hC3D4, 1'b1, 1'b1, 1'b0);
    idle(3);

    // stall on the first beat; changing inputs while busy must be ignored
    cycle(1'b1, 16'h1234, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 16'h5678, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'h9ABC, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    idle(3);

    // reset after the first beat of a word
    cycle(1'b1, 16'hCAFE, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    do_reset();
    cycle(1'b1, 16'h0077, 1'b0, 1'b1, 1'b0);
    idle(2);

    // five truncating words: 2-bit counter saturates at 3
    for (int i = 0; i < 5; i++) cycle(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b1, 1'b0);
    idle(2);
    // clear coinciding with a truncating beat transfer
    cycle(1'b1, 16'hFF00, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
    idle(2);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [15:0] d;
      d = 16'($urandom);
      if ($urandom_range(0, 1) == 0) d[15:8] = 8'h00;
      cycle($urandom_range(0, 3) != 0, d, 1'($urandom_range(0, 1)),
            $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/word_to_byte_serializer.md
Name: word_to_byte_serializer

Overview:
- Narrowing counterpart of the datapath's 8-to-16-bit zero-extend path. Accepts 16-bit words and emits them as 8-bit beats on a valid/ready byte interface, for store-byte and byte-wide I/O paths.
- Byte mode sends only the low byte (a truncation) and flags any lost non-zero upper bits. Word mode sends two beats.
- Sits between the register file / ALU result bus and the 8-bit memory/port interface.

Parameters:
- HIGH_FIRST, 0, word-mode beat order: 0 = low byte first, 1 = high byte first.
- CNT_W, 8, width of the saturating truncation-event counter.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  input word valid
- in_ready  output  1  block can accept a word this cycle
- in_data  input  16  word to narrow
- in_mode  input  1  0 = byte (1 beat), 1 = word (2 beats)
- out_valid  output  1  byte beat valid
- out_ready  input  1  downstream accepts beat
- out_data  output  8  byte beat
- out_last  output  1  final beat of current word
- trunc  output  1  current byte-mode beat lost non-zero upper byte
- trunc_cnt  output  CNT_W  saturating count of truncation events
- clr_cnt  input  1  synchronous clear of trunc_cnt
- busy  output  1  a word is in flight (state != IDLE)

Behaviour:
- Reset (async, immediate):
  - state = IDLE; out_valid = 0; out_data = 8'h00; out_last = 0; trunc = 0; trunc_cnt = 0; held word = 16'h0000.
  - A beat in flight is abandoned, not completed.
- Interface rules:
  - All outputs are registered except in_ready.
  - Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- States: IDLE, BEAT0, BEAT1.
- IDLE:
  - in_ready = 1.
  - On input transfer, latch in_data and in_mode, then go to BEAT0 next cycle with out_valid = 1.
  - Latency from input transfer to the first beat is 1 cycle.
- BEAT0:
  - Byte mode: out_data = in_data[7:0], out_last = 1, trunc = (in_data[15:8] != 0).
  - Word mode: out_data = first byte per HIGH_FIRST, out_last = 0, trunc = 0.
  - If out_ready and word mode, go to BEAT1.
  - If out_ready and byte mode, the beat is complete (see back-to-back rule below).
- BEAT1:
  - out_data = the other byte, out_last = 1, trunc = 0.
  - If out_ready, the word is complete.
- Back-to-back:
  - in_ready = 1 also in the cycle the out_last beat transfers.
  - If a new word is accepted in that cycle, go directly to BEAT0 with the new word: no bubble, so byte mode sustains 1 word/cycle and word mode 1 word per 2 cycles.
  - Otherwise return to IDLE and drop out_valid.
- Stall: while out_valid && !out_ready, out_data, out_last and trunc hold stable. in_ready = 0.
- trunc_cnt:
  - Increments by 1 on each transferred beat with trunc = 1.
  - Saturates at all-ones.
  - clr_cnt wins over a simultaneous increment; the count becomes 0.
- in_mode and in_data are sampled only at input transfer. Changes while busy are ignored.
- out_valid never deasserts without a transfer (except reset).

Decomposition:
- Shared datapath package:
  - state encoding constants for IDLE, BEAT0, BEAT1;
  - MODE_BYTE = 1'b0 and MODE_WORD = 1'b1, used by the decoder that drives in_mode;
  - a byte-width constant of 8.
- One natural sub-module, sat_counter, holding the CNT_W saturating counter with clear.
- The FSM and datapath stay in the top module.

Test Plan:
- Byte mode, out_ready = 1: in 16'h00A5 -> one beat 8'hA5, out_last = 1, trunc = 0, trunc_cnt stays 0.
- Byte mode, in 16'h12A5 -> beat 8'hA5, trunc = 1, trunc_cnt = 1. Then clr_cnt pulse -> trunc_cnt = 0.
- Word mode, HIGH_FIRST = 0: in 16'hBEEF -> beats 8'hEF (last = 0), then 8'hBE (last = 1). Repeat with HIGH_FIRST = 1 -> 8'hBE, then 8'hEF.
- Back-to-back byte words 16'h0001, 16'h0002, 16'h0003 with in_valid and out_ready held high -> beats 01, 02, 03 on consecutive cycles, no bubble.
- Stall: word 16'h1234 with out_ready low for 3 cycles on the first beat -> out_data holds 8'h34 and in_ready = 0 throughout; after release, beats 34 then 12.
- Assert reset mid-word after the first beat of 16'hCAFE -> out_valid = 0 and state IDLE immediately. Then byte word 16'h0077 -> single beat 8'h77.
- Saturation with CNT_W = 2: five truncating byte words -> trunc_cnt = 3.
